fetch: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of decode.
- Owns the program counter and drives the instruction-memory read address.
- Holds the IF/ID pipeline register (instruction, PC, PC+4, valid) that decode consumes.
- Applies redirects: jal/jalr resolved in decode, taken branches resolved in execute.
- Honours decode's load-use hold and generates the flush that kills wrong-path instructions.

---
 rtl/fetch.sv | 91 +++++++++
 tb/tb_fetch.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives the imem read address and holds
// the IF/ID register, applying decode jumps, execute branches and load-use holds.
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_hold,
  input  logic        i_jal,
  input  logic        i_jalr,
  input  logic [31:0] i_id_pc,
  input  logic [31:0] i_immediate,
  input  logic [31:0] i_jalr_rs1,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_vld,
  output logic        o_flush,
  output logic        o_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic [31:0] pc_ff;
  logic [31:0] pc_plus4;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        jump;
  logic        redirect;

  assign o_imem_raddr = pc_ff;
  assign o_flush      = i_br_taken;
  assign pc_plus4     = pc_ff + 32'd4;
  assign jal_target   = i_id_pc + i_immediate;
  assign jalr_target  = (i_jalr_rs1 + i_immediate) & ~32'h1;
  assign jump         = i_jal | i_jalr;
  // A decode jump stalled by hold is not applied yet; it re-presents later.
  assign redirect     = i_br_taken | (~i_hold & jump);

  always_comb begin
    target = jal_target;
    if (i_br_taken)
      target = i_br_target;
    else if (i_jalr)
      target = jalr_target;
  end

  always_comb begin
    next_pc = pc_plus4;
    if (i_br_taken)
      next_pc = target;
    else if (i_hold)
      next_pc = pc_ff;
    else if (jump)
      next_pc = target;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_ff      <= RESET_ADDR;
      o_inst     <= NOP;
      o_pc       <= 32'h0;
      o_nxt_pc   <= 32'h0;
      o_vld      <= 1'b0;
      o_misalign <= 1'b0;
    end else begin
      pc_ff <= next_pc;
      // Branches override hold; jumps squash the sequentially fetched word.
      if (i_br_taken || (!i_hold && jump)) begin
        o_inst <= NOP;
        o_vld  <= 1'b0;
      end else if (!i_hold) begin
        o_inst   <= i_imem_rdata;
        o_pc     <= pc_ff;
        o_nxt_pc <= pc_plus4;
        o_vld    <= 1'b1;
      end
      if (redirect)
        o_misalign <= |target[1:0];
      else if (!i_hold)
        o_misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for fetch: reset, hold, jal, jalr, branch
// priority, PC wrap and reset overriding a redirect.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr;
  logic [31:0] rdata;
  logic        hold, jal, jalr, br;
  logic [31:0] id_pc, imm, rs1, br_tgt;
  logic [31:0] inst, pc, nxt_pc;
  logic        vld, flush, mis;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch #(.RESET_ADDR(32'h0000_0100)) dut (
    .i_clk(clk), .i_rst(rst), .o_imem_raddr(raddr), .i_imem_rdata(rdata),
    .i_hold(hold), .i_jal(jal), .i_jalr(jalr), .i_id_pc(id_pc),
    .i_immediate(imm), .i_jalr_rs1(rs1), .i_br_taken(br), .i_br_target(br_tgt),
    .o_inst(inst), .o_pc(pc), .o_nxt_pc(nxt_pc), .o_vld(vld),
    .o_flush(flush), .o_misalign(mis)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  assign rdata = mem(raddr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hold = 0; jal = 0; jalr = 0; br = 0;
    id_pc = 0; imm = 0; rs1 = 0; br_tgt = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    step(); step();
    n_cmp++; if (raddr !== 32'h100) begin n_bad++; $display("[TB] FAIL rst_raddr got %h want %h", raddr, 32'h100); end
    n_cmp++; if (inst !== 32'h33) begin n_bad++; $display("[TB] FAIL rst_inst got %h want %h", inst, 32'h33); end
    n_cmp++; if ({vld, mis} !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_vld_mis got %b want 00", {vld, mis}); end
    n_cmp++; if ({pc, nxt_pc} !== 64'h0) begin n_bad++; $display("[TB] FAIL rst_pc got %h want 0", {pc, nxt_pc}); end
    rst = 0;
    step();
    n_cmp++; if (raddr !== 32'h104) begin n_bad++; $display("[TB] FAIL seq1_raddr got %h want %h", raddr, 32'h104); end
    n_cmp++; if (pc !== 32'h100 || vld !== 1'b1) begin n_bad++; $display("[TB] FAIL seq1_pc got %h/%b want 100/1", pc, vld); end
    n_cmp++; if (inst !== 32'h1357_0100 || nxt_pc !== 32'h104) begin n_bad++; $display("[TB] FAIL seq1_inst got %h/%h want 13570100/104", inst, nxt_pc); end
    step();
    n_cmp++; if (raddr !== 32'h108 || pc !== 32'h104) begin n_bad++; $display("[TB] FAIL seq2 got %h/%h want 108/104", raddr, pc); end
  endtask

  task automatic test_jal();
    jal = 1; id_pc = 32'h40; imm = 32'h80;
    step();
    n_cmp++; if (raddr !== 32'hC0) begin n_bad++; $display("[TB] FAIL jal_raddr got %h want c0", raddr); end
    n_cmp++; if (vld !== 1'b0 || inst !== 32'h33) begin n_bad++; $display("[TB] FAIL jal_bubble got %b/%h want 0/33", vld, inst); end
    clear_inputs();
    step();
    n_cmp++; if (pc !== 32'hC0 || vld !== 1'b1 || raddr !== 32'hC4) begin n_bad++; $display("[TB] FAIL jal_after got %h/%b/%h want c0/1/c4", pc, vld, raddr); end
  endtask

  task automatic test_hold();
    jal = 1; id_pc = 32'h10; imm = 32'hC;
    step();
    clear_inputs();
    step();
    hold = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (raddr !== 32'h20 || pc !== 32'h1C || vld !== 1'b1) begin n_bad++; $display("[TB] FAIL hold%0d got %h/%h/%b want 20/1c/1", i, raddr, pc, vld); end
    end
    hold = 0;
    step();
    n_cmp++; if (raddr !== 32'h24 || pc !== 32'h20) begin n_bad++; $display("[TB] FAIL hold_resume got %h/%h want 24/20", raddr, pc); end
  endtask

  task automatic test_jalr();
    jalr = 1; rs1 = 32'h1001; imm = 32'h4;
    step();
    n_cmp++; if (raddr !== 32'h1004 || mis !== 1'b0) begin n_bad++; $display("[TB] FAIL jalr_align got %h/%b want 1004/0", raddr, mis); end
    rs1 = 32'h1002; imm = 32'h0;
    step();
    n_cmp++; if (raddr !== 32'h1002 || mis !== 1'b1) begin n_bad++; $display("[TB] FAIL jalr_misalign got %h/%b want 1002/1", raddr, mis); end
    clear_inputs();
    step();
    n_cmp++; if (raddr !== 32'h1006 || mis !== 1'b0 || pc !== 32'h1002) begin n_bad++; $display("[TB] FAIL mis_clear got %h/%b/%h want 1006/0/1002", raddr, mis, pc); end
  endtask

  task automatic test_hold_jal();
    hold = 1; jal = 1; id_pc = 32'h300; imm = 32'h10;
    step();
    n_cmp++; if (raddr !== 32'h1006 || pc !== 32'h1002) begin n_bad++; $display("[TB] FAIL hold_jal got %h/%h want 1006/1002", raddr, pc); end
    hold = 0;
    step();
    n_cmp++; if (raddr !== 32'h310 || vld !== 1'b0) begin n_bad++; $display("[TB] FAIL jal_after_hold got %h/%b want 310/0", raddr, vld); end
    clear_inputs();
  endtask

  task automatic test_branch();
    br = 1; br_tgt = 32'h200; hold = 1; jal = 1; id_pc = 32'h500; imm = 32'h4;
    #1;
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_hi got %b want 1", flush); end
    step();
    n_cmp++; if (raddr !== 32'h200 || vld !== 1'b0 || inst !== 32'h33 || mis !== 1'b0) begin n_bad++; $display("[TB] FAIL br_prio got %h/%b/%h/%b want 200/0/33/0", raddr, vld, inst, mis); end
    clear_inputs();
    #1;
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_lo got %b want 0", flush); end
    step();
    n_cmp++; if (pc !== 32'h200 || vld !== 1'b1 || raddr !== 32'h204) begin n_bad++; $display("[TB] FAIL br_after got %h/%b/%h want 200/1/204", pc, vld, raddr); end
  endtask

  task automatic test_wrap();
    jal = 1; id_pc = 32'h0; imm = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    step();
    n_cmp++; if (raddr !== 32'h0 || pc !== 32'hFFFF_FFFC || nxt_pc !== 32'h0 || mis !== 1'b0) begin n_bad++; $display("[TB] FAIL wrap got %h/%h/%h/%b want 0/fffffffc/0/0", raddr, pc, nxt_pc, mis); end
  endtask

  task automatic test_reset_redirect();
    br = 1; br_tgt = 32'h202;
    step();
    n_cmp++; if (mis !== 1'b1 || raddr !== 32'h202) begin n_bad++; $display("[TB] FAIL br_misalign got %b/%h want 1/202", mis, raddr); end
    br_tgt = 32'h203; rst = 1;
    step();
    n_cmp++; if (raddr !== 32'h100 || vld !== 1'b0 || mis !== 1'b0 || pc !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_br got %h/%b/%b/%h want 100/0/0/0", raddr, vld, mis, pc); end
    rst = 0; clear_inputs();
    step();
    n_cmp++; if (pc !== 32'h100 || vld !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_br_resume got %h/%b want 100/1", pc, vld); end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_hold();
    test_jalr();
    test_hold_jal();
    test_branch();
    test_wrap();
    test_reset_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
